// File: rtl/rx_comma_align_ctrl.sv
// Word-alignment and link-sync controller: hunts for the comma, issues bit slips,
// declares lock after a comma run, forwards comma-stripped payload and watches comma spacing.
module rx_comma_align_ctrl #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         LOCK_COMMAS = 4,
  parameter int         SEARCH_WIN  = 16,
  parameter int         SETTLE_CYC  = 2,
  parameter int         MAX_GAP     = 32
) (
  input  logic       i_clk,
  input  logic       i_reset_L,
  input  logic [7:0] i_data_in,
  input  logic       i_data_in_en,
  output logic       o_bitslip,
  output logic       o_sync_ok,
  output logic [7:0] o_data_out,
  output logic       o_valid_out,
  output logic [2:0] o_slip_count,
  output logic       o_comma_err
);

  localparam int WIN_W = $clog2(SEARCH_WIN + 1);
  localparam int CNT_W = $clog2(LOCK_COMMAS + 1);
  localparam int GAP_W = $clog2(MAX_GAP + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(SEARCH_WIN - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_COMMAS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(MAX_GAP - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HUNT   = 3'd1,
    S_SETTLE = 3'd2,
    S_VERIFY = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIN_W-1:0] r_win_cnt,    w_win_next;
  logic [CNT_W-1:0] r_comma_cnt,  w_comma_next;
  logic [GAP_W-1:0] r_gap_cnt,    w_gap_next;
  logic [SET_W-1:0] r_settle_cnt, w_settle_next;

  logic       r_bitslip,    w_bitslip_next;
  logic       r_sync_ok,    w_sync_next;
  logic [7:0] r_data_out;
  logic       r_valid_out,  w_valid_next;
  logic [2:0] r_slip_count;
  logic       r_comma_err,  w_comma_err_next;

  logic w_is_comma;
  logic w_en_comma;
  logic w_en_data;
  logic w_win_full;
  logic w_gap_full;

  assign w_is_comma = (i_data_in == COMMA);
  assign w_en_comma = i_data_in_en && w_is_comma;
  assign w_en_data  = i_data_in_en && !w_is_comma;
  assign w_win_full = (r_win_cnt == WIN_LAST);
  assign w_gap_full = (r_gap_cnt == GAP_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_reset_L) begin
    if (!i_reset_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    w_state_next  = r_state;
    w_win_next    = r_win_cnt;
    w_comma_next  = r_comma_cnt;
    w_gap_next    = r_gap_cnt;
    w_settle_next = r_settle_cnt;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_HUNT;
        w_win_next   = '0;
      end
      S_HUNT: begin
        if (w_en_comma) begin
          w_state_next = S_VERIFY;
          w_comma_next = CNT_W'(1);
        end else if (w_en_data) begin
          if (w_win_full) begin
            w_state_next  = S_SETTLE;
            w_win_next    = '0;
            w_settle_next = '0;
          end else begin
            w_win_next = r_win_cnt + WIN_W'(1);
          end
        end
      end
      S_SETTLE: begin
        // Deserializer output is unstable right after a slip; counts raw clocks.
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_next  = S_HUNT;
          w_win_next    = '0;
          w_settle_next = '0;
        end else begin
          w_settle_next = r_settle_cnt + SET_W'(1);
        end
      end
      S_VERIFY: begin
        if (w_en_comma) begin
          if (r_comma_cnt == LOCK_LAST) begin
            w_state_next = S_LOCKED;
            w_gap_next   = '0;
          end
          w_comma_next = r_comma_cnt + CNT_W'(1);
        end else if (w_en_data) begin
          w_state_next = S_HUNT;
          w_win_next   = WIN_W'(1);
        end
      end
      S_LOCKED: begin
        if (w_en_comma) begin
          w_gap_next = '0;
        end else if (w_en_data) begin
          if (w_gap_full) begin
            w_state_next = S_HUNT;
            w_win_next   = '0;
            w_gap_next   = '0;
          end else begin
            w_gap_next = r_gap_cnt + GAP_W'(1);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    w_bitslip_next   = 1'b0;
    w_valid_next     = 1'b0;
    w_comma_err_next = 1'b0;
    case (r_state)
      S_HUNT: begin
        w_bitslip_next = w_en_data && w_win_full;
      end
      S_LOCKED: begin
        w_comma_err_next = w_en_data && w_gap_full;
        w_valid_next     = w_en_data && !w_gap_full;
      end
      default: begin
        w_bitslip_next = 1'b0;
      end
    endcase
    w_sync_next = (w_state_next == S_LOCKED);
  end

  always_ff @(posedge i_clk or negedge i_reset_L) begin
    if (!i_reset_L) begin
      r_win_cnt    <= '0;
      r_comma_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_settle_cnt <= '0;
      r_bitslip    <= 1'b0;
      r_sync_ok    <= 1'b0;
      r_data_out   <= 8'h00;
      r_valid_out  <= 1'b0;
      r_slip_count <= 3'd0;
      r_comma_err  <= 1'b0;
    end else begin
      r_win_cnt    <= w_win_next;
      r_comma_cnt  <= w_comma_next;
      r_gap_cnt    <= w_gap_next;
      r_settle_cnt <= w_settle_next;
      r_bitslip    <= w_bitslip_next;
      r_sync_ok    <= w_sync_next;
      r_valid_out  <= w_valid_next;
      r_comma_err  <= w_comma_err_next;
      if (w_bitslip_next) begin
        r_slip_count <= r_slip_count + 3'd1;
      end
      if (i_data_in_en) begin
        r_data_out <= i_data_in;
      end
    end
  end

  assign o_bitslip    = r_bitslip;
  assign o_sync_ok    = r_sync_ok;
  assign o_data_out   = r_data_out;
  assign o_valid_out  = r_valid_out;
  assign o_slip_count = r_slip_count;
  assign o_comma_err  = r_comma_err;

endmodule

// File: tb/tb_rx_comma_align_ctrl.sv
// Bench for rx_comma_align_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a byte-level behavioural model of the link rules.
module tb_rx_comma_align_ctrl;

  logic       i_clk;
  logic       i_reset_L;
  logic [7:0] i_data_in;
  logic       i_data_in_en;
  logic       o_bitslip;
  logic       o_sync_ok;
  logic [7:0] o_data_out;
  logic       o_valid_out;
  logic [2:0] o_slip_count;
  logic       o_comma_err;

  rx_comma_align_ctrl dut (
    .i_clk        (i_clk),
    .i_reset_L    (i_reset_L),
    .i_data_in    (i_data_in),
    .i_data_in_en (i_data_in_en),
    .o_bitslip    (o_bitslip),
    .o_sync_ok    (o_sync_ok),
    .o_data_out   (o_data_out),
    .o_valid_out  (o_valid_out),
    .o_slip_count (o_slip_count),
    .o_comma_err  (o_comma_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec;
  int n_err;

  // Reference model: link phase plus run lengths, in plain integers
  localparam int P_START = 0, P_HUNT = 1, P_WAIT = 2, P_CHECK = 3, P_LOCK = 4;
  int         m_phase;
  int         m_noncomma_run;
  int         m_comma_run;
  int         m_gap;
  int         m_wait_left;
  int         m_slips;
  logic       e_bitslip, e_sync, e_valid, e_err;
  logic [7:0] e_data;
  int         n_bitslip_seen, n_valid_seen, n_err_seen;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_START; m_noncomma_run = 0; m_comma_run = 0; m_gap = 0;
    m_wait_left = 0; m_slips = 0;
    e_bitslip = 0; e_sync = 0; e_valid = 0; e_err = 0; e_data = 8'h00;
  endtask

  task automatic model_clock(input logic [7:0] d, input logic en);
    bit comma;
    comma = (d == 8'hBC);
    e_bitslip = 0; e_valid = 0; e_err = 0;
    if (en) e_data = d;
    case (m_phase)
      P_START: begin m_phase = P_HUNT; m_noncomma_run = 0; end
      P_HUNT: if (en) begin
        if (comma) begin m_phase = P_CHECK; m_comma_run = 1; end
        else begin
          m_noncomma_run++;
          if (m_noncomma_run == 16) begin
            e_bitslip = 1; m_slips = (m_slips + 1) % 8;
            m_phase = P_WAIT; m_wait_left = 2;
          end
        end
      end
      P_WAIT: begin
        m_wait_left--;
        if (m_wait_left == 0) begin m_phase = P_HUNT; m_noncomma_run = 0; end
      end
      P_CHECK: if (en) begin
        if (comma) begin
          m_comma_run++;
          if (m_comma_run == 4) begin m_phase = P_LOCK; m_gap = 0; end
        end else begin m_phase = P_HUNT; m_noncomma_run = 1; end
      end
      P_LOCK: if (en) begin
        if (comma) m_gap = 0;
        else begin
          m_gap++;
          if (m_gap == 32) begin e_err = 1; m_phase = P_HUNT; m_noncomma_run = 0; end
          else e_valid = 1;
        end
      end
      default: m_phase = P_START;
    endcase
    e_sync = (m_phase == P_LOCK);
  endtask

  task automatic compare_all();
    chk("bitslip",    {7'd0, o_bitslip},    {7'd0, e_bitslip});
    chk("sync_ok",    {7'd0, o_sync_ok},    {7'd0, e_sync});
    chk("valid_out",  {7'd0, o_valid_out},  {7'd0, e_valid});
    chk("comma_err",  {7'd0, o_comma_err},  {7'd0, e_err});
    chk("slip_count", {5'd0, o_slip_count}, 8'(m_slips));
    chk("data_out",   o_data_out,           e_data);
    chk("slip_err_excl", {7'd0, o_bitslip & o_comma_err}, 8'h00);
  endtask

  // One clock of traffic: drive after negedge, model at posedge, compare at next negedge
  task automatic step(input logic [7:0] d, input logic en);
    i_data_in = d; i_data_in_en = en;
    @(posedge i_clk);
    model_clock(d, en);
    @(negedge i_clk);
    compare_all();
    if (o_bitslip) n_bitslip_seen++;
    if (o_valid_out) n_valid_seen++;
    if (o_comma_err) n_err_seen++;
    $display("t=%0t en=%0b din=%02h | slip=%0b sync=%0b dout=%02h vld=%0b cnt=%0d err=%0b",
             $time, en, d, o_bitslip, o_sync_ok, o_data_out, o_valid_out, o_slip_count, o_comma_err);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bitslip"}, {7'd0, o_bitslip}, 8'h00);
    chk({tag, "_sync"},    {7'd0, o_sync_ok}, 8'h00);
    chk({tag, "_data"},    o_data_out, 8'h00);
    chk({tag, "_valid"},   {7'd0, o_valid_out}, 8'h00);
    chk({tag, "_slipcnt"}, {5'd0, o_slip_count}, 8'h00);
    chk({tag, "_err"},     {7'd0, o_comma_err}, 8'h00);
  endtask

  // Async reset asserted between clock edges; outputs must clear before any edge
  task automatic async_reset(input string tag);
    @(negedge i_clk);
    #2 i_reset_L = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
    i_data_in_en = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset_L = 1'b1;
    step(8'h00, 1'b0);  // leaves IDLE
  endtask

  task automatic lock_link();
    repeat (4) step(8'hBC, 1'b1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    n_bitslip_seen = 0; n_valid_seen = 0; n_err_seen = 0;
    i_reset_L = 1'b0; i_data_in = 8'h00; i_data_in_en = 1'b0;
    model_reset();
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_reset_L = 1'b1;
    step(8'h00, 1'b0);

    // 1: lock then two payload bytes
    lock_link();
    chk("t1_sync_after_4th", {7'd0, o_sync_ok}, 8'h01);
    step(8'h11, 1'b1);
    chk("t1_d11", o_data_out, 8'h11);
    chk("t1_v11", {7'd0, o_valid_out}, 8'h01);
    step(8'h22, 1'b1);
    chk("t1_d22", o_data_out, 8'h22);
    chk("t1_no_slip", 8'(n_bitslip_seen), 8'h00);

    // 2: incomplete comma run returns to hunt
    async_reset("t2_rst");
    repeat (3) step(8'hBC, 1'b1);
    step(8'h55, 1'b1);
    chk("t2_sync", {7'd0, o_sync_ok}, 8'h00);
    chk("t2_valid", {7'd0, o_valid_out}, 8'h00);

    // 3: slip windows, eight of them wrap the slip counter
    async_reset("t3_rst");
    n_bitslip_seen = 0;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 18; k++) step(8'h00, 1'b1);
      if (w == 0) chk("t3_first_slip_cnt", {5'd0, o_slip_count}, 8'h01);
    end
    chk("t3_slip_pulses", 8'(n_bitslip_seen), 8'h08);
    chk("t3_wrap", {5'd0, o_slip_count}, 8'h00);

    // 4: loss of sync after 32 non-commas, then relock
    lock_link();
    n_valid_seen = 0; n_err_seen = 0;
    repeat (32) step(8'hA5, 1'b1);
    chk("t4_valid_pulses", 8'(n_valid_seen), 8'd31);
    chk("t4_err_pulse", 8'(n_err_seen), 8'd1);
    chk("t4_sync_drop", {7'd0, o_sync_ok}, 8'h00);
    step(8'h00, 1'b0);
    lock_link();
    chk("t4_relock", {7'd0, o_sync_ok}, 8'h01);

    // 5: gappy enable while locked
    n_err_seen = 0;
    for (int k = 0; k < 60; k++) step(8'($urandom_range(0, 8'hBB)), k[0] == 1'b0);
    chk("t5_no_err", 8'(n_err_seen), 8'h00);
    chk("t5_still_locked", {7'd0, o_sync_ok}, 8'h01);

    // 6: async reset mid-lock
    step(8'h42, 1'b1);
    async_reset("t6_rst");
    chk("t6_slip_zero", {5'd0, o_slip_count}, 8'h00);

    // Randomized traffic with varying comma density
    for (int blk = 0; blk < 40; blk++) begin
      int pct;
      pct = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 30 : 90);
      for (int k = 0; k < 40; k++) begin
        logic [7:0] d;
        logic       e;
        d = ($urandom_range(0, 99) < pct) ? 8'hBC : 8'($urandom);
        e = ($urandom_range(0, 4) != 0);
        step(d, e);
      end
      if (blk == 20) async_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
